divide_arbiter: RTL and testbench

- Clocked round-robin arbiter that shares one self-timed `divide` datapath among NUM_CLI requesters.
- Converts each accepted client request into a 4-phase req/fin handshake toward the divider and synchronizes the asynchronous `fin` into the clock domain.
- Returns quotient and remainder to the winning client as a one-cycle response tagged with the client ID.
- Sits between the clocked compute clients and the clockless math macros.

---
 rtl/divide_arbiter_pkg.sv | 22 ++
 rtl/divide_arbiter_rr_pick.sv | 30 +++
 rtl/divide_arbiter.sv | 157 +++++++++++++++
 tb/tb_divide_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divide_arbiter_pkg.sv
// Shared FSM encodings and constants for divide_arbiter.
// The zero-bypass state is only reachable when DIVIDE_ARBITER_ZERO_BYPASS_EN is defined.
package divide_arbiter_pkg;

  localparam int unsigned STW = 3;

  localparam logic [STW-1:0] ST_DRAIN   = 3'd0;
  localparam logic [STW-1:0] ST_IDLE    = 3'd1;
  localparam logic [STW-1:0] ST_SETUP   = 3'd2;
  localparam logic [STW-1:0] ST_REQ     = 3'd3;
  localparam logic [STW-1:0] ST_CAPTURE = 3'd4;
  localparam logic [STW-1:0] ST_RELEASE = 3'd5;
  localparam logic [STW-1:0] ST_ZERO    = 3'd6;

  localparam int unsigned MAX_W = 64;

  // Quotient reported for a bypassed divide-by-zero: all ones at width w.
  function automatic logic [MAX_W-1:0] quot_all_ones(input int unsigned w);
    quot_all_ones = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

endpackage

// File: rtl/divide_arbiter_rr_pick.sv
// Combinational round-robin picker: first request at or after ptr_i, wrapping modulo N.
module divide_arbiter_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = IW'((32'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o      = 1'b1;
        idx_o      = j;
        grant_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/divide_arbiter.sv
// Round-robin arbiter sharing one self-timed divider via a 4-phase req/fin handshake.
// Optional DIVIDE_ARBITER_ZERO_BYPASS_EN answers b==0 locally and adds rsp_dz.
module divide_arbiter
  import divide_arbiter_pkg::*;
#(
  parameter int unsigned AWidth  = 32,
  parameter int unsigned BWidth  = 32,
  parameter int unsigned NUM_CLI = 4,
  parameter int unsigned IDW     = $clog2(NUM_CLI)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CLI-1:0]        cli_valid,
  output logic [NUM_CLI-1:0]        cli_ack,
  input  logic [NUM_CLI*AWidth-1:0] cli_a,
  input  logic [NUM_CLI*BWidth-1:0] cli_b,
  output logic                      rsp_valid,
  output logic [IDW-1:0]            rsp_id,
  output logic [AWidth-1:0]         rsp_s,
  output logic [BWidth-1:0]         rsp_mod,
  output logic                      busy,
  output logic                      div_req,
  input  logic                      div_fin,
  output logic [AWidth-1:0]         div_a,
  output logic [BWidth-1:0]         div_b,
  input  logic [AWidth-1:0]         div_s,
  input  logic [BWidth-1:0]         div_mod
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
  ,
  output logic                      rsp_dz
`endif
);

  logic [STW-1:0]     state_q, state_d;
  logic               fin_meta_q, fin_s_q;
  logic [1:0]         prime_q;
  logic [IDW-1:0]     rr_ptr_q, id_q;
  logic [NUM_CLI-1:0] cli_ack_q;
  logic               rsp_valid_q, div_req_q, busy_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [AWidth-1:0]  rsp_s_q, div_a_q;
  logic [BWidth-1:0]  rsp_mod_q, div_b_q;
  logic               rsp_dz_q;

  logic [NUM_CLI-1:0] grant;
  logic [IDW-1:0]     gidx;
  logic               gany;
  logic [AWidth-1:0]  sel_a;
  logic [BWidth-1:0]  sel_b;
  logic               take;

  divide_arbiter_rr_pick #(.N(NUM_CLI), .IW(IDW)) u_pick (
    .req_i   (cli_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (gidx),
    .any_o   (gany)
  );

  assign sel_a = cli_a[32'(gidx)*AWidth +: AWidth];
  assign sel_b = cli_b[32'(gidx)*BWidth +: BWidth];
  assign take  = (state_q == ST_IDLE) && gany;

  // DRAIN also waits for the synchronizer to fill so a divider still high after reset is seen.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DRAIN:   if (prime_q[1] && !fin_s_q) state_d = ST_IDLE;
      ST_IDLE: begin
        if (gany) begin
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
          state_d = (sel_b == '0) ? ST_ZERO : ST_SETUP;
`else
          state_d = ST_SETUP;
`endif
        end
      end
      ST_SETUP:   state_d = ST_REQ;
      ST_REQ:     if (fin_s_q) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_RELEASE;
      ST_RELEASE: if (!fin_s_q) state_d = ST_IDLE;
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
      ST_ZERO:    state_d = ST_IDLE;
`endif
      default:    state_d = ST_DRAIN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_DRAIN;
      fin_meta_q  <= 1'b0;
      fin_s_q     <= 1'b0;
      prime_q     <= '0;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      cli_ack_q   <= '0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      div_req_q   <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_mod_q   <= '0;
      rsp_dz_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      fin_meta_q  <= div_fin;
      fin_s_q     <= fin_meta_q;
      prime_q     <= {prime_q[0], 1'b1};
      cli_ack_q   <= take ? grant : '0;
      div_req_q   <= (state_d == ST_REQ);
      busy_q      <= (state_d != ST_IDLE);
      rsp_valid_q <= 1'b0;
      rsp_dz_q    <= 1'b0;
      if (take) begin
        div_a_q  <= sel_a;
        div_b_q  <= sel_b;
        id_q     <= gidx;
        rr_ptr_q <= IDW'((32'(gidx) + 32'd1) % NUM_CLI);
      end
      if (state_q == ST_CAPTURE) begin
        rsp_s_q     <= div_s;
        rsp_mod_q   <= div_mod;
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
      end
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
      if (state_q == ST_ZERO) begin
        rsp_s_q     <= AWidth'(quot_all_ones(AWidth));
        rsp_mod_q   <= BWidth'(div_a_q);
        rsp_id_q    <= id_q;
        rsp_valid_q <= 1'b1;
        rsp_dz_q    <= 1'b1;
      end
`endif
    end
  end

  assign cli_ack   = cli_ack_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_mod   = rsp_mod_q;
  assign busy      = busy_q;
  assign div_req   = div_req_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
  assign rsp_dz    = rsp_dz_q;
`else
  logic unused_dz;
  assign unused_dz = rsp_dz_q;
`endif

endmodule

// File: tb/tb_divide_arbiter.sv
// Directed bench for divide_arbiter with a behavioural self-timed divider.
module tb_divide_arbiter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   cli_valid;
  logic [3:0]   cli_ack;
  logic [127:0] cli_a = '0;
  logic [127:0] cli_b = '0;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_s, rsp_mod;
  logic         busy, div_req;
  logic         div_fin = 1'b0;
  logic [31:0]  div_a, div_b;
  logic [31:0]  div_s = '0;
  logic [31:0]  div_mod = '0;
  logic         rsp_dz;

  int checks = 0;
  int errors = 0;

  int req_cnt [4] = '{0, 0, 0, 0};
  int ack_cnt [4] = '{0, 0, 0, 0};
  int grants[$];
  int rq_id[$];
  logic [31:0] rq_s[$];
  logic [31:0] rq_m[$];
  logic rq_dz[$];
  int req_rises = 0;
  logic req_prev = 1'b0;
  int fin_dly = 12;
  int rel_dly = 12;

  divide_arbiter dut (
    .clk(clk), .rst(rst), .cli_valid(cli_valid), .cli_ack(cli_ack),
    .cli_a(cli_a), .cli_b(cli_b), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_s(rsp_s), .rsp_mod(rsp_mod), .busy(busy), .div_req(div_req),
    .div_fin(div_fin), .div_a(div_a), .div_b(div_b), .div_s(div_s),
    .div_mod(div_mod)
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
    , .rsp_dz(rsp_dz)
`endif
  );

`ifndef DIVIDE_ARBITER_ZERO_BYPASS_EN
  assign rsp_dz = 1'b0;
`endif

  always #5 clk = ~clk;

  // A client keeps requesting while it has outstanding transactions.
  always_comb begin
    for (int i = 0; i < 4; i++) cli_valid[i] = (ack_cnt[i] < req_cnt[i]);
  end

  // Self-timed divider: fin rises fin_dly after req, falls rel_dly after req drops.
  always begin
    @(posedge div_req);
    #(fin_dly);
    div_s   = (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
    div_mod = (div_b == 0) ? div_a : div_a % div_b;
    div_fin = 1'b1;
    if (div_req) @(negedge div_req);
    #(rel_dly);
    div_fin = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (cli_ack[i]) begin
          grants.push_back(i);
          ack_cnt[i] = ack_cnt[i] + 1;
        end
      end
      if (rsp_valid) begin
        rq_id.push_back(int'(rsp_id));
        rq_s.push_back(rsp_s);
        rq_m.push_back(rsp_mod);
        rq_dz.push_back(rsp_dz);
      end
      if (div_req && !req_prev) req_rises = req_rises + 1;
    end
    req_prev = div_req;
  end

  task automatic set_ops(input int c, input logic [31:0] a, input logic [31:0] b);
    cli_a[c*32 +: 32] = a;
    cli_b[c*32 +: 32] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) req_cnt[i] = ack_cnt[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
  endtask

  task automatic wait_rsps(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rq_id.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (rq_id.size() < n) begin
      errors++;
      $display("FAIL %s timeout: responses=%0d required=%0d", tag, rq_id.size(), n);
    end
    k = 0;
    while (busy && k < 400) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (cli_ack !== 4'b0)  begin errors++; $display("FAIL reset_ack got=%h exp=0", cli_ack); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (div_req !== 1'b0)  begin errors++; $display("FAIL reset_div_req got=%b exp=0", div_req); end
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL reset_busy got=%b exp=1", busy); end
    checks++; if (div_a !== 32'd0 || div_b !== 32'd0) begin errors++; $display("FAIL reset_div_ops got=%h/%h exp=0/0", div_a, div_b); end
    checks++; if (rsp_s !== 32'd0 || rsp_mod !== 32'd0 || rsp_id !== 2'd0) begin
      errors++; $display("FAIL reset_rsp got=%h/%h/%0d exp=0/0/0", rsp_s, rsp_mod, rsp_id);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int gb, rb, rr, cyc, ack_c, rsp_c;
    do_reset();
    fin_dly = 12; rel_dly = 12;
    set_ops(1, 32'd100, 32'd7);
    gb = grants.size(); rb = rq_id.size(); rr = req_rises;
    ack_c = -1; rsp_c = -1; cyc = 0;
    req_cnt[1] = req_cnt[1] + 1;
    while (rsp_c < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cli_ack[1]) ack_c = cyc;
      if (rsp_valid) rsp_c = cyc;
    end
    wait_rsps(rb + 1, 50, "single");
    checks++; if (grants.size() != gb + 1 || grants[gb] != 1) begin
      errors++; $display("FAIL single_grant count=%0d exp=1", grants.size() - gb);
    end
    checks++; if (rsp_c - ack_c < 5 || rsp_c - ack_c > 8) begin
      errors++; $display("FAIL single_latency got=%0d exp=5..8", rsp_c - ack_c);
    end
    if (rq_id.size() > rb) begin
      checks++; if (rq_id[rb] != 1 || rq_s[rb] !== 32'd14 || rq_m[rb] !== 32'd2) begin
        errors++; $display("FAIL single_rsp got=%0d/%0d/%0d exp=1/14/2", rq_id[rb], rq_s[rb], rq_m[rb]);
      end
      checks++; if (rq_dz[rb] !== 1'b0) begin errors++; $display("FAIL single_dz got=%b exp=0", rq_dz[rb]); end
    end
    checks++; if (req_rises != rr + 1) begin errors++; $display("FAIL single_req_rises got=%0d exp=1", req_rises - rr); end
    checks++; if (div_req !== 1'b0) begin errors++; $display("FAIL single_req_after got=%b exp=0", div_req); end
  endtask

  task automatic test_contention();
    int gb, rb;
    logic [31:0] es [4] = '{32'd100, 32'd15, 32'h5555_5555, 32'd12};
    logic [31:0] em [4] = '{32'd0, 32'd2, 32'd0, 32'd345};
    do_reset();
    set_ops(0, 32'd1000, 32'd10);
    set_ops(1, 32'd77, 32'd5);
    set_ops(2, 32'hFFFF_FFFF, 32'd3);
    set_ops(3, 32'd12345, 32'd1000);
    gb = grants.size(); rb = rq_id.size();
    for (int i = 0; i < 4; i++) req_cnt[i] = req_cnt[i] + 1;
    wait_rsps(rb + 4, 400, "contention");
    for (int i = 0; i < 4; i++) begin
      if (grants.size() > gb + i) begin
        checks++; if (grants[gb+i] != i) begin errors++; $display("FAIL contention_grant[%0d] got=%0d exp=%0d", i, grants[gb+i], i); end
      end
      if (rq_id.size() > rb + i) begin
        checks++; if (rq_id[rb+i] != i || rq_s[rb+i] !== es[i] || rq_m[rb+i] !== em[i]) begin
          errors++; $display("FAIL contention_rsp[%0d] got=%0d/%h/%h exp=%0d/%h/%h", i, rq_id[rb+i], rq_s[rb+i], rq_m[rb+i], i, es[i], em[i]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    int gb, rb;
    int exp_g [6] = '{0, 2, 0, 2, 0, 2};
    do_reset();
    set_ops(0, 32'd9, 32'd4);
    set_ops(2, 32'd30, 32'd7);
    gb = grants.size(); rb = rq_id.size();
    req_cnt[0] = req_cnt[0] + 3;
    req_cnt[2] = req_cnt[2] + 3;
    wait_rsps(rb + 6, 600, "fairness");
    checks++; if (grants.size() != gb + 6) begin errors++; $display("FAIL fairness_count got=%0d exp=6", grants.size() - gb); end
    for (int i = 0; i < 6; i++) begin
      if (grants.size() > gb + i) begin
        checks++; if (grants[gb+i] != exp_g[i]) begin errors++; $display("FAIL fairness_grant[%0d] got=%0d exp=%0d", i, grants[gb+i], exp_g[i]); end
      end
    end
  endtask

  task automatic test_reset_midop();
    int rb, cyc, fall_c, ack_c;
    do_reset();
    fin_dly = 12; rel_dly = 150;
    set_ops(0, 32'd50, 32'd6);
    req_cnt[0] = req_cnt[0] + 1;
    cyc = 0;
    while (!div_fin && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (div_fin !== 1'b1 || div_req !== 1'b1) begin
      errors++; $display("FAIL midop_in_req fin=%b req=%b exp=1/1", div_fin, div_req);
    end
    rst = 1'b1;
    #1;
    checks++; if (div_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL midop_reset req=%b busy=%b exp=0/1", div_req, busy);
    end
    rb = rq_id.size();
    set_ops(1, 32'd20, 32'd3);
    req_cnt[1] = req_cnt[1] + 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    fall_c = -1; ack_c = -1; cyc = 0;
    while (ack_c < 0 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (!div_fin && fall_c < 0) fall_c = cyc;
      if (cli_ack[1]) ack_c = cyc;
    end
    checks++; if (ack_c < 0 || fall_c < 0 || ack_c - fall_c < 2) begin
      errors++; $display("FAIL midop_drain ack_cyc=%0d fall_cyc=%0d exp=ack at least 2 after fall", ack_c, fall_c);
    end
    rel_dly = 12;
    wait_rsps(rb + 1, 100, "midop");
    checks++; if (rq_id.size() != rb + 1) begin errors++; $display("FAIL midop_rsp_count got=%0d exp=1", rq_id.size() - rb); end
    if (rq_id.size() > rb) begin
      checks++; if (rq_id[rb] != 1 || rq_s[rb] !== 32'd6 || rq_m[rb] !== 32'd2) begin
        errors++; $display("FAIL midop_rsp got=%0d/%0d/%0d exp=1/6/2", rq_id[rb], rq_s[rb], rq_m[rb]);
      end
    end
  endtask

  task automatic test_slow_release();
    int rb, cyc, fall_c, ack_c;
    do_reset();
    fin_dly = 12; rel_dly = 200;
    set_ops(0, 32'd9, 32'd2);
    rb = rq_id.size();
    req_cnt[0] = req_cnt[0] + 1;
    cyc = 0;
    while (rq_id.size() <= rb && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    set_ops(3, 32'd40, 32'd6);
    req_cnt[3] = req_cnt[3] + 1;
    fall_c = -1; ack_c = -1; cyc = 0;
    while (ack_c < 0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == 5) begin
        checks++; if (busy !== 1'b1 || div_fin !== 1'b1) begin errors++; $display("FAIL slow_hold busy=%b fin=%b exp=1/1", busy, div_fin); end
      end
      if (!div_fin && fall_c < 0) fall_c = cyc;
      if (cli_ack[3]) ack_c = cyc;
    end
    checks++; if (ack_c < 15 || fall_c < 0 || ack_c - fall_c < 2) begin
      errors++; $display("FAIL slow_ack ack_cyc=%0d fall_cyc=%0d exp=ack at least 2 after fall", ack_c, fall_c);
    end
    rel_dly = 12;
    wait_rsps(rb + 2, 300, "slow");
    if (rq_id.size() > rb + 1) begin
      checks++; if (rq_id[rb] != 0 || rq_s[rb] !== 32'd4 || rq_m[rb] !== 32'd1) begin
        errors++; $display("FAIL slow_rsp0 got=%0d/%0d/%0d exp=0/4/1", rq_id[rb], rq_s[rb], rq_m[rb]);
      end
      checks++; if (rq_id[rb+1] != 3 || rq_s[rb+1] !== 32'd6 || rq_m[rb+1] !== 32'd4) begin
        errors++; $display("FAIL slow_rsp3 got=%0d/%0d/%0d exp=3/6/4", rq_id[rb+1], rq_s[rb+1], rq_m[rb+1]);
      end
    end
  endtask

  task automatic test_zero();
    int rb, rr, exp_rises;
    logic exp_dz;
`ifdef DIVIDE_ARBITER_ZERO_BYPASS_EN
    exp_rises = 0; exp_dz = 1'b1;
`else
    exp_rises = 1; exp_dz = 1'b0;
`endif
    do_reset();
    fin_dly = 12; rel_dly = 12;
    set_ops(2, 32'h1234, 32'd0);
    rb = rq_id.size(); rr = req_rises;
    req_cnt[2] = req_cnt[2] + 1;
    wait_rsps(rb + 1, 100, "zero");
    checks++; if (req_rises - rr != exp_rises) begin errors++; $display("FAIL zero_div_req rises=%0d exp=%0d", req_rises - rr, exp_rises); end
    if (rq_id.size() > rb) begin
      checks++; if (rq_id[rb] != 2 || rq_s[rb] !== 32'hFFFF_FFFF || rq_m[rb] !== 32'h1234) begin
        errors++; $display("FAIL zero_rsp got=%0d/%h/%h exp=2/ffffffff/1234", rq_id[rb], rq_s[rb], rq_m[rb]);
      end
      checks++; if (rq_dz[rb] !== exp_dz) begin errors++; $display("FAIL zero_dz got=%b exp=%b", rq_dz[rb], exp_dz); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_reset_midop();
    test_slow_release();
    test_zero();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
